// File: rtl/union_lane_splitter_pkg.sv
// Shared types and helpers for the union lane splitter.
package union_lane_pkg;

  typedef enum logic [1:0] {IDLE, PAR, SER} ul_state_t;

  localparam int unsigned DONE_W = 16;

  // Width of a lane index; never narrower than one bit.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    int unsigned w;
    w = $clog2(lanes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/union_lane_splitter_if.sv
// Input/output stream bundle for the union lane splitter.
interface union_lane_splitter_if
  import union_lane_pkg::*;
#(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 2
) ();

  localparam int unsigned IN_W  = LANES * LANE_W;
  localparam int unsigned IDX_W = lane_idx_w(LANES);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_flat;
  logic              in_serial;
  logic              out_valid;
  logic              out_ready;
  logic [IN_W-1:0]   out_flat;
  logic [IDX_W-1:0]  out_lane;
  logic              out_last;
  logic [DONE_W-1:0] words_done;

  // Stimulus source / downstream sink side.
  modport master (
    output in_valid, in_flat, in_serial, out_ready,
    input  in_ready, out_valid, out_flat, out_lane, out_last, words_done
  );

  // Splitter side.
  modport slave (
    input  in_valid, in_flat, in_serial, out_ready,
    output in_ready, out_valid, out_flat, out_lane, out_last, words_done
  );

endinterface

// File: rtl/union_lane_splitter_fifo.sv
// Synchronous FIFO holding {serial_mode, word} entries.
module union_lane_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_q, wr_d;
  logic [PTR_W:0] rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign data_o  = mem_q[rd_q[PTR_W-1:0]];

  // Pointer advance; the extra MSB separates full from empty.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + (PTR_W+1)'(1);
    if (pop_i && !empty_o) rd_d = rd_q + (PTR_W+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/union_lane_splitter.sv
// Splits queued words into lanes and emits them reordered-parallel or one lane per beat.
module union_lane_splitter
  import union_lane_pkg::*;
#(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  union_lane_splitter_if.slave bus
);

  localparam int unsigned       IN_W     = LANES * LANE_W;
  localparam int unsigned       FIFO_W   = IN_W + 1;
  localparam int unsigned       IDX_W    = lane_idx_w(LANES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [DONE_W-1:0] DONE_MAX = '1;

  logic              fifo_full, fifo_empty;
  logic              push_c, pop_c;
  logic [FIFO_W-1:0] fifo_dout;
  logic              head_serial_c;
  logic [IN_W-1:0]   head_word_c, head_par_c, head_ser0_c, ser_next_c;
  logic [IDX_W-1:0]  lane_nxt_c;

  ul_state_t         state_q;
  logic              out_valid_q, out_last_q;
  logic [IN_W-1:0]   out_flat_q, word_q;
  logic [IDX_W-1:0]  out_lane_q;
  logic [DONE_W-1:0] words_done_q;

  assign push_c                      = bus.in_valid && !fifo_full;
  assign bus.in_ready                = !fifo_full;
  assign {head_serial_c, head_word_c} = fifo_dout;
  assign lane_nxt_c                  = out_lane_q + IDX_W'(1);

  union_lane_fifo #(.DEPTH(DEPTH), .W(FIFO_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .data_i  ({bus.in_serial, bus.in_flat}),
    .pop_i   (pop_c),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pop whenever the output register is free or its final beat is being taken.
  always_comb begin
    pop_c = 1'b0;
    unique case (state_q)
      IDLE:    pop_c = !fifo_empty;
      PAR:     pop_c = bus.out_ready && !fifo_empty;
      SER:     pop_c = bus.out_ready && (out_lane_q == LAST_IDX) && !fifo_empty;
      default: pop_c = 1'b0;
    endcase
  end

  // Beat formatting: reversed lane order for parallel, zero-extended lane for serial.
  always_comb begin
    head_par_c  = '0;
    head_ser0_c = '0;
    ser_next_c  = '0;
    head_ser0_c[LANE_W-1:0] = head_word_c[LANE_W-1:0];
    for (int unsigned k = 0; k < LANES; k++) begin
      head_par_c[(LANES-1-k)*LANE_W +: LANE_W] = head_word_c[k*LANE_W +: LANE_W];
      if (lane_nxt_c == IDX_W'(k)) ser_next_c[LANE_W-1:0] = word_q[k*LANE_W +: LANE_W];
    end
  end

  // Control FSM and output register; a pop always reloads without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_flat_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      word_q      <= '0;
    end else if (pop_c) begin
      word_q      <= head_word_c;
      out_valid_q <= 1'b1;
      out_lane_q  <= '0;
      if (head_serial_c) begin
        state_q    <= SER;
        out_flat_q <= head_ser0_c;
        out_last_q <= 1'b0;
      end else begin
        state_q    <= PAR;
        out_flat_q <= head_par_c;
        out_last_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        PAR: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        SER: begin
          if (bus.out_ready) begin
            if (out_lane_q == LAST_IDX) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end else begin
              out_lane_q <= lane_nxt_c;
              out_flat_q <= ser_next_c;
              out_last_q <= (lane_nxt_c == LAST_IDX);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Completed-word counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_done_q <= '0;
    end else if (out_valid_q && bus.out_ready && out_last_q && (words_done_q != DONE_MAX)) begin
      words_done_q <= words_done_q + DONE_W'(1);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_flat   = out_flat_q;
  assign bus.out_lane   = out_lane_q;
  assign bus.out_last   = out_last_q;
  assign bus.words_done = words_done_q;

endmodule

// File: tb/tb_union_lane_splitter.sv
// Bench for union_lane_splitter: word-level reference model plus directed literal checks.
module tb_union_lane_splitter;
  import union_lane_pkg::*;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned IN_W   = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  union_lane_splitter_if #(.LANE_W(LANE_W), .LANES(LANES)) bus ();

  union_lane_splitter #(.LANE_W(LANE_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [IN_W-1:0] flat;
    int              lane;
    bit              last;
    int              cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  beat_t b_m;
  int    inflight;
  int    done_m;
  bit    pushed_last;
  bit    ev_m;
  int    cyc;
  int    checks;
  int    errors;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of one word, straight from the lane-mapping rules.
  function automatic void add_word(input logic [IN_W-1:0] w, input bit ser);
    beat_t b;
    if (!ser) begin
      b.flat = '0;
      for (int k = 0; k < int'(LANES); k++)
        b.flat[(int'(LANES)-1-k)*int'(LANE_W) +: LANE_W] = w[k*int'(LANE_W) +: LANE_W];
      b.lane = 0;
      b.last = 1'b1;
      b.cyc  = 0;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < int'(LANES); k++) begin
        b.flat = '0;
        b.flat[LANE_W-1:0] = w[k*int'(LANE_W) +: LANE_W];
        b.lane = k;
        b.last = (k == int'(LANES) - 1);
        b.cyc  = 0;
        exp_q.push_back(b);
      end
    end
  endfunction

  // Per-cycle comparison of DUT against the model, then model update for the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      inflight    = 0;
      done_m      = 0;
      pushed_last = 1'b0;
      chk("in_ready_in_reset", longint'(bus.in_ready), 1);
      chk("out_valid_in_reset", longint'(bus.out_valid), 0);
      chk("words_done_in_reset", longint'(bus.words_done), 0);
    end else begin
      ev_m = ((inflight - (pushed_last ? 1 : 0)) > 0);
      chk("out_valid", longint'(bus.out_valid), longint'(ev_m));
      chk("in_ready", longint'(bus.in_ready), longint'((inflight - int'(ev_m)) < int'(DEPTH)));
      chk("words_done", longint'(bus.words_done), longint'(done_m));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("out_flat", longint'(bus.out_flat), longint'(exp_q[0].flat));
          chk("out_lane", longint'(bus.out_lane), longint'(exp_q[0].lane));
          chk("out_last", longint'(bus.out_last), longint'(exp_q[0].last));
          if (bus.out_ready) begin
            b_m = exp_q.pop_front();
            if (b_m.last) begin
              inflight--;
              if (done_m < 65535) done_m++;
            end
            b_m.flat = bus.out_flat;
            b_m.lane = int'(bus.out_lane);
            b_m.last = bus.out_last;
            b_m.cyc  = cyc;
            log_q.push_back(b_m);
          end
        end
      end
      pushed_last = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        add_word(bus.in_flat, bus.in_serial);
        inflight++;
        pushed_last = 1'b1;
      end
    end
  end

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic push_word(input logic [IN_W-1:0] w, input bit ser);
    bit acc;
    bus.in_valid  = 1'b1;
    bus.in_flat   = w;
    bus.in_serial = ser;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    chk("push_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (inflight == 0 && !bus.out_valid) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic chk_beat(input string nm, input int i, input logic [IN_W-1:0] flat,
                          input int lane, input bit last);
    if (log_q.size() <= i) begin
      chk({nm, "_missing"}, longint'(log_q.size()), longint'(i + 1));
    end else begin
      chk({nm, "_flat"}, longint'(log_q[i].flat), longint'(flat));
      chk({nm, "_lane"}, longint'(log_q[i].lane), longint'(lane));
      chk({nm, "_last"}, longint'(log_q[i].last), longint'(last));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_flat   = '0;
    bus.in_serial = 1'b0;
    bus.out_ready = 1'b1;
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    chk("reset_out_flat", longint'(bus.out_flat), 0);
    chk("reset_out_lane", longint'(bus.out_lane), 0);
    chk("reset_out_last", longint'(bus.out_last), 0);

    // Parallel, back to back
    push_word(16'hABCD, 1'b0);
    push_word(16'h1234, 1'b0);
    drain();
    chk_beat("t1_w0", 0, 16'hCDAB, 0, 1'b1);
    chk_beat("t1_w1", 1, 16'h3412, 0, 1'b1);
    if (log_q.size() >= 2) chk("t1_consecutive", longint'(log_q[1].cyc - log_q[0].cyc), 1);
    chk("t1_words_done", longint'(bus.words_done), 2);

    // Serial single word
    do_reset();
    push_word(16'hABCD, 1'b1);
    drain();
    chk_beat("t2_b0", 0, 16'h00CD, 0, 1'b0);
    chk_beat("t2_b1", 1, 16'h00AB, 1, 1'b1);
    chk("t2_words_done", longint'(bus.words_done), 1);

    // Backpressure with a full FIFO
    do_reset();
    bus.out_ready = 1'b0;
    push_word(16'hA1B2, 1'b0);
    push_word(16'hC3D4, 1'b1);
    push_word(16'hE5F6, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_flat   = 16'h0708;
    bus.in_serial = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready_low", longint'(bus.in_ready), 0);
      chk("t3_out_hold", longint'(bus.out_flat), 16'hB2A1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push_word(16'h0708, 1'b0);
    drain();
    chk_beat("t3_w0", 0, 16'hB2A1, 0, 1'b1);
    chk_beat("t3_w1a", 1, 16'h00D4, 0, 1'b0);
    chk_beat("t3_w1b", 2, 16'h00C3, 1, 1'b1);
    chk_beat("t3_w2", 3, 16'hF6E5, 0, 1'b1);
    chk_beat("t3_w3", 4, 16'h0807, 0, 1'b1);
    chk("t3_count", longint'(log_q.size()), 5);

    // Mixed modes
    do_reset();
    push_word(16'h1111, 1'b0);
    push_word(16'h2233, 1'b1);
    push_word(16'h4455, 1'b0);
    drain();
    chk_beat("t4_b0", 0, 16'h1111, 0, 1'b1);
    chk_beat("t4_b1", 1, 16'h0033, 0, 1'b0);
    chk_beat("t4_b2", 2, 16'h0022, 1, 1'b1);
    chk_beat("t4_b3", 3, 16'h5544, 0, 1'b1);

    // Reset in the middle of a serial word
    do_reset();
    push_word(16'hABCD, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (log_q.size() >= 1) break;
    end
    chk("t5_beat0_seen", longint'(log_q.size()), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid_now", longint'(bus.out_valid), 0);
    chk("t5_words_done_now", longint'(bus.words_done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_residual", longint'(log_q.size()), 1);
    chk("t5_idle_valid", longint'(bus.out_valid), 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_serial = 1'($urandom_range(0, 1));
      bus.in_flat   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("rand_queue_empty", longint'(exp_q.size()), 0);

    // Saturation of words_done
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_serial = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      bus.in_flat = 16'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("t6_saturated", longint'(bus.words_done), 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
